// File: rtl/fft4_pipe.sv
// fft4_pipe: two-stage pipelined 4-point radix-2 DIT FFT/IFFT with
// valid/ready handshakes on both sides.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     input frame handshake
//   in_inv                0 = forward, 1 = inverse (travels with the frame)
//   in_re/in_im           4 samples of DW bits, sample n at [n*DW +: DW]
//   out_valid/out_ready   output frame handshake
//   out_inv               mode bit of the frame on the output
//   out_re/out_im         4 bins of DW+2 bits, bin k at [k*(DW+2) +: DW+2]
module fft4_pipe #(
    parameter int DW        = 4,
    parameter bit INV_SCALE = 1'b0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic                in_inv,
    input  logic [4*DW-1:0]     in_re,
    input  logic [4*DW-1:0]     in_im,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                out_inv,
    output logic [4*(DW+2)-1:0] out_re,
    output logic [4*(DW+2)-1:0] out_im
);

    localparam int W1 = DW + 1;
    localparam int W2 = DW + 2;

    logic en;
    logic accept;

    // Whole pipe advances together; a stalled output freezes everything.
    assign en       = !out_valid || out_ready;
    assign in_ready = en && rst_n;
    assign accept   = in_valid && in_ready;

    // Stage 1: first butterfly layer on sign-extended inputs
    logic signed [W1-1:0] xr [4];
    logic signed [W1-1:0] xi [4];
    logic signed [W1-1:0] br [4];
    logic signed [W1-1:0] bi [4];

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            xr[n] = {in_re[n*DW+DW-1], in_re[n*DW +: DW]};
            xi[n] = {in_im[n*DW+DW-1], in_im[n*DW +: DW]};
        end
        br[0] = xr[0] + xr[2];
        bi[0] = xi[0] + xi[2];
        br[1] = xr[0] - xr[2];
        bi[1] = xi[0] - xi[2];
        br[2] = xr[1] + xr[3];
        bi[2] = xi[1] + xi[3];
        br[3] = xr[1] - xr[3];
        bi[3] = xi[1] - xi[3];
    end

    logic signed [W1-1:0] sr [4];
    logic signed [W1-1:0] si [4];
    logic                 v1;
    logic                 inv1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1   <= 1'b0;
            inv1 <= 1'b0;
            for (int n = 0; n < 4; n++) begin
                sr[n] <= '0;
                si[n] <= '0;
            end
        end else if (en) begin
            v1 <= accept;
            if (accept) begin
                inv1 <= in_inv;
                for (int n = 0; n < 4; n++) begin
                    sr[n] <= br[n];
                    si[n] <= bi[n];
                end
            end
        end
    end

    // Stage 2: second layer; s3 is rotated by -j (forward) or +j (inverse)
    logic signed [W2-1:0] er [4];
    logic signed [W2-1:0] ei [4];
    logic signed [W2-1:0] rr;
    logic signed [W2-1:0] ri;
    logic signed [W2-1:0] yr [4];
    logic signed [W2-1:0] yi [4];
    logic signed [W2-1:0] zr [4];
    logic signed [W2-1:0] zi [4];

    always_comb begin
        for (int n = 0; n < 4; n++) begin
            er[n] = {sr[n][W1-1], sr[n]};
            ei[n] = {si[n][W1-1], si[n]};
        end
        // -j*(a+jb) = b-ja ; +j*(a+jb) = -b+ja
        rr = inv1 ? -ei[3] : ei[3];
        ri = inv1 ? er[3] : -er[3];
        yr[0] = er[0] + er[2];
        yi[0] = ei[0] + ei[2];
        yr[2] = er[0] - er[2];
        yi[2] = ei[0] - ei[2];
        yr[1] = er[1] + rr;
        yi[1] = ei[1] + ri;
        yr[3] = er[1] - rr;
        yi[3] = ei[1] - ri;
        for (int k = 0; k < 4; k++) begin
            zr[k] = yr[k];
            zi[k] = yi[k];
            if (INV_SCALE && inv1) begin
                zr[k] = yr[k] >>> 2;
                zi[k] = yi[k] >>> 2;
            end
        end
    end

    logic signed [W2-1:0] or_q [4];
    logic signed [W2-1:0] oi_q [4];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_inv   <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                or_q[k] <= '0;
                oi_q[k] <= '0;
            end
        end else if (en) begin
            out_valid <= v1;
            if (v1) begin
                out_inv <= inv1;
                for (int k = 0; k < 4; k++) begin
                    or_q[k] <= zr[k];
                    oi_q[k] <= zi[k];
                end
            end
        end
    end

    for (genvar k = 0; k < 4; k++) begin : g_pack
        assign out_re[k*W2 +: W2] = or_q[k];
        assign out_im[k*W2 +: W2] = oi_q[k];
    end

endmodule

// File: tb/tb_fft4_pipe.sv
// tb_fft4_pipe: directed vectors for fft4_pipe (DW=4 unscaled, DW=6 scaled),
// plus backpressure streaming and mid-flight reset sequences.
module tb_fft4_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT A: DW=4, INV_SCALE=0
    logic        v4 = 1'b0;
    logic        r4;
    logic        inv4 = 1'b0;
    logic [15:0] re4 = '0;
    logic [15:0] im4 = '0;
    logic        ov4;
    logic        ordy4 = 1'b1;
    logic        oinv4;
    logic [23:0] ore4;
    logic [23:0] oim4;

    // DUT B: DW=6, INV_SCALE=1
    logic        v6 = 1'b0;
    logic        r6;
    logic        inv6 = 1'b0;
    logic [23:0] re6 = '0;
    logic [23:0] im6 = '0;
    logic        ov6;
    logic        ordy6 = 1'b1;
    logic        oinv6;
    logic [31:0] ore6;
    logic [31:0] oim6;

    fft4_pipe #(.DW(4), .INV_SCALE(1'b0)) u4 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v4), .in_ready(r4), .in_inv(inv4),
        .in_re(re4), .in_im(im4),
        .out_valid(ov4), .out_ready(ordy4), .out_inv(oinv4),
        .out_re(ore4), .out_im(oim4)
    );

    fft4_pipe #(.DW(6), .INV_SCALE(1'b1)) u6 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(v6), .in_ready(r6), .in_inv(inv6),
        .in_re(re6), .in_im(im6),
        .out_valid(ov6), .out_ready(ordy6), .out_inv(oinv6),
        .out_re(ore6), .out_im(oim6)
    );

    int total = 0;
    int bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic chkv(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        bit sel;
        bit inv;
        int xr [4];
        int xi [4];
        int er [4];
        int ei [4];
    } vec_t;

    typedef struct packed {
        logic [23:0] re;
        logic [23:0] im;
        logic        inv;
    } res_t;

    // Direct 4-point DFT, DW=4 in, DW+2 out, no scaling
    function automatic res_t model(input logic [15:0] re,
                                   input logic [15:0] im,
                                   input logic inv);
        res_t r;
        r.inv = inv;
        r.re = '0;
        r.im = '0;
        for (int k = 0; k < 4; k++) begin
            int ar = 0;
            int ai = 0;
            for (int n = 0; n < 4; n++) begin
                int a = int'($signed(re[n*4 +: 4]));
                int b = int'($signed(im[n*4 +: 4]));
                int c = 0;
                int d = 0;
                case ((n * k) % 4)
                    0: begin c = 1; d = 0; end
                    1: begin c = 0; d = inv ? 1 : -1; end
                    2: begin c = -1; d = 0; end
                    default: begin c = 0; d = inv ? -1 : 1; end
                endcase
                ar += a * c - b * d;
                ai += a * d + b * c;
            end
            r.re[k*6 +: 6] = 6'(ar);
            r.im[k*6 +: 6] = 6'(ai);
        end
        return r;
    endfunction

    task automatic run_vec(input int idx, input vec_t v);
        string nm;
        @(negedge clk);
        for (int n = 0; n < 4; n++) begin
            re4[n*4 +: 4] = 4'(v.xr[n]);
            im4[n*4 +: 4] = 4'(v.xi[n]);
            re6[n*6 +: 6] = 6'(v.xr[n]);
            im6[n*6 +: 6] = 6'(v.xi[n]);
        end
        inv4 = v.inv;
        inv6 = v.inv;
        if (v.sel) v6 = 1'b1;
        else v4 = 1'b1;
        @(negedge clk);
        v4 = 1'b0;
        v6 = 1'b0;
        @(negedge clk);
        nm = $sformatf("vec%0d", idx);
        if (v.sel) begin
            chk({nm, "_valid"}, int'(ov6), 1);
            chk({nm, "_inv"}, int'(oinv6), int'(v.inv));
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("%s_re%0d", nm, k),
                    int'($signed(ore6[k*8 +: 8])), v.er[k]);
                chk($sformatf("%s_im%0d", nm, k),
                    int'($signed(oim6[k*8 +: 8])), v.ei[k]);
            end
        end else begin
            chk({nm, "_valid"}, int'(ov4), 1);
            chk({nm, "_inv"}, int'(oinv4), int'(v.inv));
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("%s_re%0d", nm, k),
                    int'($signed(ore4[k*6 +: 6])), v.er[k]);
                chk($sformatf("%s_im%0d", nm, k),
                    int'($signed(oim4[k*6 +: 6])), v.ei[k]);
            end
        end
    endtask

    vec_t vt [11];
    logic [15:0] fre [12];
    logic [15:0] fim [12];
    res_t q [$];
    res_t e;

    initial begin
        vt[0]  = '{1'b0, 1'b0, '{1, 2, 3, 4}, '{0, 0, 0, 0},
                   '{10, -2, -2, -2}, '{0, 2, 0, -2}};
        vt[1]  = '{1'b0, 1'b1, '{1, 2, 3, 4}, '{0, 0, 0, 0},
                   '{10, -2, -2, -2}, '{0, -2, 0, 2}};
        vt[2]  = '{1'b0, 1'b0, '{-8, -8, -8, -8}, '{0, 0, 0, 0},
                   '{-32, 0, 0, 0}, '{0, 0, 0, 0}};
        vt[3]  = '{1'b0, 1'b0, '{7, 7, 7, 7}, '{7, 7, 7, 7},
                   '{28, 0, 0, 0}, '{28, 0, 0, 0}};
        vt[4]  = '{1'b0, 1'b1, '{-8, -8, -8, -8}, '{-8, -8, -8, -8},
                   '{-32, 0, 0, 0}, '{-32, 0, 0, 0}};
        vt[5]  = '{1'b0, 1'b0, '{-8, 0, 0, 0}, '{7, 0, 0, 0},
                   '{-8, -8, -8, -8}, '{7, 7, 7, 7}};
        vt[6]  = '{1'b0, 1'b0, '{0, 1, 0, 0}, '{0, 0, 0, 0},
                   '{1, 0, -1, 0}, '{0, -1, 0, 1}};
        vt[7]  = '{1'b1, 1'b1, '{10, -2, -2, -2}, '{0, 2, 0, -2},
                   '{1, 2, 3, 4}, '{0, 0, 0, 0}};
        vt[8]  = '{1'b1, 1'b1, '{-1, 0, 0, 0}, '{0, 0, 0, 0},
                   '{-1, -1, -1, -1}, '{0, 0, 0, 0}};
        vt[9]  = '{1'b1, 1'b0, '{-5, 0, 0, 0}, '{0, 0, 0, 0},
                   '{-5, -5, -5, -5}, '{0, 0, 0, 0}};
        vt[10] = '{1'b1, 1'b1, '{7, 0, 0, 0}, '{0, 0, 0, 0},
                   '{1, 1, 1, 1}, '{0, 0, 0, 0}};

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ov", int'(ov4), 0);
        chk("rst_rdy", int'(r4), 0);
        chk("rst_inv", int'(oinv4), 0);
        chkv("rst_re", {8'h0, ore4}, 32'h0);
        chkv("rst_im", {8'h0, oim4}, 32'h0);
        chk("rst_ov6", int'(ov6), 0);
        rst_n = 1'b1;
        #1;
        chk("rdy_after_rst", int'(r4), 1);

        // directed table
        for (int i = 0; i < 11; i++) run_vec(i, vt[i]);

        // backpressure stream
        for (int i = 0; i < 12; i++) begin
            fre[i] = 16'($urandom);
            fim[i] = 16'($urandom);
        end
        begin
            int sent = 0;
            int got = 0;
            int cyc = 0;
            bit held = 0;
            logic [23:0] sre = '0;
            logic [23:0] sim = '0;
            logic sinv = 1'b0;
            while (got < 12 && cyc < 500) begin
                @(negedge clk);
                cyc++;
                ordy4 = 1'($urandom_range(0, 1));
                v4 = (sent < 12);
                if (sent < 12) begin
                    re4 = fre[sent];
                    im4 = fim[sent];
                    inv4 = sent[0];
                end
                #1;
                chk("bp_rdy", int'(r4), int'(!(ov4 && !ordy4)));
                if (held) begin
                    chkv("hold_re", {8'h0, ore4}, {8'h0, sre});
                    chkv("hold_im", {8'h0, oim4}, {8'h0, sim});
                    chk("hold_inv", int'(oinv4), int'(sinv));
                end
                held = ov4 && !ordy4;
                sre = ore4;
                sim = oim4;
                sinv = oinv4;
                if (ov4 && ordy4) begin
                    if (q.size() == 0) begin
                        chk("bp_extra_frame", 1, 0);
                    end else begin
                        e = q.pop_front();
                        chkv($sformatf("bp%0d_re", got),
                             {8'h0, ore4}, {8'h0, e.re});
                        chkv($sformatf("bp%0d_im", got),
                             {8'h0, oim4}, {8'h0, e.im});
                        chk($sformatf("bp%0d_inv", got),
                            int'(oinv4), int'(e.inv));
                    end
                    got++;
                end
                if (v4 && r4) begin
                    q.push_back(model(re4, im4, inv4));
                    sent++;
                end
            end
            if (got < 12) chk("bp_timeout", got, 12);
        end
        @(negedge clk);
        v4 = 1'b0;
        ordy4 = 1'b1;
        repeat (3) @(negedge clk);
        chk("bp_drained", int'(ov4), 0);

        // reset with two frames in flight
        @(negedge clk);
        re4 = 16'h4321;
        im4 = 16'h1234;
        inv4 = 1'b0;
        v4 = 1'b1;
        @(negedge clk);
        re4 = 16'h7777;
        inv4 = 1'b1;
        @(negedge clk);
        v4 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rstmid_rdy", int'(r4), 0);
        @(negedge clk);
        chk("rstmid_ov", int'(ov4), 0);
        chkv("rstmid_re", {8'h0, ore4}, 32'h0);
        chkv("rstmid_im", {8'h0, oim4}, 32'h0);
        chk("rstmid_inv", int'(oinv4), 0);
        rst_n = 1'b1;
        re4 = 16'h20F3;
        im4 = 16'h0E10;
        inv4 = 1'b1;
        v4 = 1'b1;
        e = model(re4, im4, inv4);
        #1;
        chk("post_rst_rdy", int'(r4), 1);
        @(negedge clk);
        v4 = 1'b0;
        chk("post_rst_lat1", int'(ov4), 0);
        @(negedge clk);
        chk("post_rst_lat2", int'(ov4), 1);
        chkv("post_rst_re", {8'h0, ore4}, {8'h0, e.re});
        chkv("post_rst_im", {8'h0, oim4}, {8'h0, e.im});
        chk("post_rst_inv", int'(oinv4), 1);
        repeat (3) begin
            @(negedge clk);
            chk("no_ghost", int'(ov4), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft4_pipe.md
# fft4_pipe

Parametrised, pipelined 4-point radix-2 DIT FFT/IFFT core with complex signed inputs and valid/ready handshakes on both sides. It succeeds the fixed-width combinational four-point transform. It adds configurable sample width, a per-frame forward/inverse mode, optional 1/N scaling on inverse, and a two-stage registered datapath with backpressure. It sits between the sample framer and the spectral post-processing stage.

## Interface
- DW, default 4: signed input sample width, real and imaginary parts each; legal range 2..16.
- INV_SCALE, default 0: if 1, inverse-mode results are arithmetic-shifted right by 2 (divide by N=4); forward results are never scaled.
- clk  in  1  single clock, all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- in_valid  in  1  input frame valid.
- in_ready  out  1  core can accept a frame this cycle.
- in_inv  in  1  0 = forward DFT, 1 = inverse; captured with the frame.
- in_re  in  4*DW  real parts; sample n at [n*DW +: DW], two's complement.
- in_im  in  4*DW  imaginary parts, same packing.
- out_valid  out  1  output frame valid.
- out_ready  in  1  downstream accepts the frame.
- out_inv  out  1  mode bit carried with the frame.
- out_re  out  4*(DW+2)  real parts of bins k=0..3; bin k at [k*(DW+2) +: DW+2].
- out_im  out  4*(DW+2)  imaginary parts, same packing.

## Operation
- Accept occurs when in_valid && in_ready. Transfer occurs when out_valid && out_ready.
- Global advance enable is en = !out_valid || out_ready. in_ready = en && rst_n.
- Stage 1 registers, width DW+1, sign-extended before each add:
  - s0 = x0+x2
  - s1 = x0-x2
  - s2 = x1+x3
  - s3 = x1-x3
  - Each is complex. Stage 1 also registers v1 and inv1.
- Stage 2 registers, width DW+2:
  - X0 = s0+s2
  - X2 = s0-s2
- Forward (inv=0), multiply s3 by -j:
  - X1 = (s1re+s3im) + j(s1im-s3re)
  - X3 = (s1re-s3im) + j(s1im+s3re)
- Inverse (inv=1), multiply s3 by +j:
  - X1 = (s1re-s3im) + j(s1im+s3re)
  - X3 = (s1re+s3im) + j(s1im-s3re)
- If INV_SCALE=1 and inv=1, all eight stage-2 results are arithmetic-shifted right by 2, which floors toward -inf. The result is kept at DW+2 bits, sign-extended.
- Widths are lossless: with no scaling, no result can overflow DW+2 bits.
- When en=1, all stages shift together:
  - v1 <= accept.
  - stage-1 data <= butterfly of the inputs, but only on accept; otherwise the data holds.
  - out_valid <= v1.
  - Stage-2 data loads from stage 1 only when v1=1.
- Bubbles are not compressed; a gap at the input appears as a gap at the output.
- When en=0, every register holds, including stage 1 even if v1=0.
- Mode is per frame. Consecutive frames may alternate in_inv with no penalty.

## Timing
- Latency: a frame accepted at edge k has out_valid=1 after edge k+1.
- Throughput: 1 frame per cycle while out_ready=1.
- Stall: if out_valid=1 and out_ready=0, then in_ready=0 in the same cycle (combinational). out_re, out_im and out_inv stay stable until the transfer.
- Simultaneous events: a transfer and an accept in the same cycle are legal. Output is replaced by the next frame or a bubble, with no loss.
- out_ready may be asserted while out_valid=0 and has no effect.
- Reset, with rst_n=0 at an edge:
  - v1 = 0, out_valid = 0, out_inv = 0.
  - All data registers = 0.
  - in_ready = 0 while rst_n=0.
- Reset mid-operation discards in-flight frames. The first accept is possible in the first cycle with rst_n=1.
- in_ready and out_valid never go X after reset.

## Test plan
- Forward, DW=4, out_ready=1, real inputs (1,2,3,4) with im=0. Required two cycles after accept: X0=10, X1=-2+2j, X2=-2, X3=-2-2j, out_inv=0.
- Inverse, INV_SCALE=0, same inputs. Required: X0=10, X1=-2-2j, X2=-2, X3=-2+2j, out_inv=1.
- Round trip, DW=6, INV_SCALE=1, inverse on inputs (10, -2+2j, -2, -2-2j). Required: (1,2,3,4) with all im=0.
- Extremes, DW=4:
  - All inputs -8+0j: X0=-32, others 0.
  - All inputs 7+7j: X0=28+28j, others 0.
  - Both cases with no wrap.
- Backpressure: stream 12 frames back-to-back with alternating in_inv, and out_ready toggled randomly. Required:
  - Every frame is delivered once, in order, and matches the reference model.
  - The output is stable while stalled.
  - in_ready=0 exactly when out_valid && !out_ready.
- Reset: pull rst_n low for one cycle with 2 frames in flight. Required:
  - out_valid=0 and outputs 0 after that edge.
  - The in-flight frames never appear.
  - A frame accepted in the next cycle emerges with latency 2.
